// File: rtl/hack_cpu_pkg.sv
// Types and field positions shared by the Hack CPU and its ALU.
`include "hack_defs.v"

package hack_cpu_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned ADDR_W     = 15;

  localparam int unsigned OPCODE_BIT = `HACK_OPCODE_BIT;
  localparam int unsigned A_BIT      = `HACK_A_BIT;
  localparam int unsigned COMP_MSB   = `HACK_COMP_MSB;
  localparam int unsigned COMP_LSB   = `HACK_COMP_LSB;
  localparam int unsigned DEST_A_BIT = `HACK_DEST_A_BIT;
  localparam int unsigned DEST_D_BIT = `HACK_DEST_D_BIT;
  localparam int unsigned DEST_M_BIT = `HACK_DEST_M_BIT;
  localparam int unsigned JLT_BIT    = `HACK_JLT_BIT;
  localparam int unsigned JEQ_BIT    = `HACK_JEQ_BIT;
  localparam int unsigned JGT_BIT    = `HACK_JGT_BIT;

  localparam logic [ADDR_W-1:0] RESET_PC = `HACK_RESET_PC;

  typedef enum logic {
    INSTR_A = 1'b0,
    INSTR_C = 1'b1
  } instr_kind_e;

  // Field order matches the comp bits [11:6] of a C-instruction.
  typedef struct packed {
    logic zx;
    logic nx;
    logic zy;
    logic ny;
    logic f;
    logic no;
  } alu_ctrl_t;

  function automatic logic jump_taken(input logic jlt, input logic jeq,
                                      input logic jgt, input logic zr,
                                      input logic ng);
    return (jlt & ng) | (jeq & zr) | (jgt & ~ng & ~zr);
  endfunction

endpackage

// File: rtl/hack_cpu_alu.sv
// Hack ALU: six-bit controlled add/and unit with zero and negative flags.
module hack_cpu_alu
  import hack_cpu_pkg::*;
(
  input  logic [DATA_W-1:0] x_i,
  input  logic [DATA_W-1:0] y_i,
  input  alu_ctrl_t         ctrl_i,
  output logic [DATA_W-1:0] out_o,
  output logic              zr_o,
  output logic              ng_o
);

  logic [DATA_W-1:0] x_z, x_n, y_z, y_n, res;

  always_comb begin
    x_z   = ctrl_i.zx ? '0 : x_i;
    x_n   = ctrl_i.nx ? ~x_z : x_z;
    y_z   = ctrl_i.zy ? '0 : y_i;
    y_n   = ctrl_i.ny ? ~y_z : y_z;
    res   = ctrl_i.f ? (x_n + y_n) : (x_n & y_n);
    out_o = ctrl_i.no ? ~res : res;
    zr_o  = (out_o == '0);
    ng_o  = out_o[DATA_W-1];
  end

endmodule

// File: rtl/hack_defs.v
// Shared Hack instruction-word field positions and the reset PC value.
`ifndef HACK_DEFS_V
`define HACK_DEFS_V

`define HACK_OPCODE_BIT   15
`define HACK_A_BIT        12
`define HACK_COMP_MSB     11
`define HACK_COMP_LSB     6
`define HACK_DEST_A_BIT   5
`define HACK_DEST_D_BIT   4
`define HACK_DEST_M_BIT   3
`define HACK_JLT_BIT      2
`define HACK_JEQ_BIT      1
`define HACK_JGT_BIT      0
`define HACK_RESET_PC     15'h0000

`endif

// File: rtl/hack_cpu.sv
// Hack CPU core: A/D/PC registers, instruction decode, jump and PC logic.
module hack_cpu
  import hack_cpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [DATA_W-1:0] instruction,
  input  logic [DATA_W-1:0] inM,
  output logic [DATA_W-1:0] outM,
  output logic              writeM,
  output logic [ADDR_W-1:0] addressM,
  output logic [ADDR_W-1:0] pc
);

  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  instr_kind_e       kind;
  alu_ctrl_t         alu_ctrl;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W-1:0] alu_out;
  logic              alu_zr, alu_ng;
  logic              jump;

  assign kind     = instr_kind_e'(instruction[OPCODE_BIT]);
  assign alu_ctrl = alu_ctrl_t'(instruction[COMP_MSB:COMP_LSB]);
  assign alu_y    = instruction[A_BIT] ? inM : a_q;

  hack_cpu_alu u_alu (
    .x_i    (d_q),
    .y_i    (alu_y),
    .ctrl_i (alu_ctrl),
    .out_o  (alu_out),
    .zr_o   (alu_zr),
    .ng_o   (alu_ng)
  );

  assign jump = (kind == INSTR_C) &&
                jump_taken(instruction[JLT_BIT], instruction[JEQ_BIT],
                           instruction[JGT_BIT], alu_zr, alu_ng);

  assign outM     = alu_out;
  assign writeM   = (kind == INSTR_C) & instruction[DEST_M_BIT] & enable & reset_n;
  assign addressM = a_q[ADDR_W-1:0];
  assign pc       = pc_q;

  // NOTE: every next-state value gets a hold default first so no path
  // through this block leaves a variable unassigned (which would infer a latch).
  always_comb begin
    a_d  = a_q;
    d_d  = d_q;
    pc_d = pc_q;
    if (enable) begin
      if (kind == INSTR_A) begin
        a_d = {1'b0, instruction[ADDR_W-1:0]};
      end else begin
        if (instruction[DEST_A_BIT]) a_d = alu_out;
        if (instruction[DEST_D_BIT]) d_d = alu_out;
      end
      // Jump target is the A value before this edge's update.
      pc_d = jump ? a_q[ADDR_W-1:0] : pc_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q  <= '0;
      d_q  <= '0;
      pc_q <= RESET_PC;
    end else begin
      a_q  <= a_d;
      d_q  <= d_d;
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_hack_cpu.sv
// Directed bench for hack_cpu: stimulus pushes expected outputs, a monitor pops and compares.
module tb_hack_cpu;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic [15:0] instruction;
  logic [15:0] inM;
  logic [15:0] outM;
  logic        writeM;
  logic [14:0] addressM;
  logic [14:0] pc;

  hack_cpu dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .instruction (instruction),
    .inM         (inM),
    .outM        (outM),
    .writeM      (writeM),
    .addressM    (addressM),
    .pc          (pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        chk_out;
    logic [15:0] out;
    logic        wm;
    logic [14:0] addr;
    logic [14:0] pcv;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
    end
  endtask

  // Monitor: samples the DUT two time units after each expectation is posted.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      #2;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_underflow: got empty queue, expected an entry");
      end else begin
        e = sb.pop_front();
        if (e.chk_out) check({e.name, ".outM"}, outM, e.out);
        check({e.name, ".writeM"}, {15'b0, writeM}, {15'b0, e.wm});
        check({e.name, ".addressM"}, {1'b0, addressM}, {1'b0, e.addr});
        check({e.name, ".pc"}, {1'b0, pc}, {1'b0, e.pcv});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

  task automatic drive(input logic [15:0] ins, input logic [15:0] m, input logic en);
    instruction = ins;
    inM         = m;
    enable      = en;
  endtask

  task automatic expect_out(input string name, input logic chk_o, input logic [15:0] o,
                            input logic wm, input logic [14:0] a, input logic [14:0] p);
    exp_t e;
    e.name = name; e.chk_out = chk_o; e.out = o; e.wm = wm; e.addr = a; e.pcv = p;
    sb.push_back(e);
    -> sample_ev;
    #3;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // 0xE300 computes D with no destination: outM exposes D without changing state.
  task automatic probe_d(input string name, input logic [15:0] d,
                         input logic [14:0] a, input logic [14:0] p);
    drive(16'hE300, 16'h0000, 1'b0);
    expect_out(name, 1'b1, d, 1'b0, a, p);
    tick();
  endtask

  task automatic do_reset();
    drive(16'hE300, 16'h0000, 1'b0);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(16'hE7C8, 16'h0000, 1'b1);
    #2;
    expect_out("reset_state", 1'b1, 16'h0001, 1'b0, 15'h0000, 15'h0000);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Load: @21 then D=A
    drive(16'h0015, 16'h0000, 1'b1);
    expect_out("load_at", 1'b0, 16'h0000, 1'b0, 15'h0000, 15'h0000);
    tick();
    drive(16'hEC10, 16'h0000, 1'b1);
    expect_out("load_d_eq_a", 1'b1, 16'h0015, 1'b0, 15'h0015, 15'h0001);
    tick();
    probe_d("load_d", 16'h0015, 15'h0015, 15'h0002);
    drive(16'hEC00, 16'h0000, 1'b0);
    expect_out("load_a", 1'b1, 16'h0015, 1'b0, 15'h0015, 15'h0002);
    tick();

    // Conditional jump taken (D=5 > 0)
    do_reset();
    drive(16'h0005, 16'h0000, 1'b1); tick();
    drive(16'hEC10, 16'h0000, 1'b1); tick();
    drive(16'h0064, 16'h0000, 1'b1); tick();
    drive(16'hE301, 16'h0000, 1'b1);
    expect_out("jgt_pre", 1'b1, 16'h0005, 1'b0, 15'd100, 15'd3);
    tick();
    probe_d("jgt_taken", 16'h0005, 15'd100, 15'd100);

    // Conditional jump not taken (D=0)
    do_reset();
    drive(16'h0000, 16'h0000, 1'b1); tick();
    drive(16'hEC10, 16'h0000, 1'b1); tick();
    drive(16'h0064, 16'h0000, 1'b1); tick();
    drive(16'hE301, 16'h0000, 1'b1);
    expect_out("jgt0_pre", 1'b1, 16'h0000, 1'b0, 15'd100, 15'd3);
    tick();
    probe_d("jgt_not_taken", 16'h0000, 15'd100, 15'd4);

    // Memory write: A=0x1234, D=7, M=D+1
    do_reset();
    drive(16'h0007, 16'h0000, 1'b1); tick();
    drive(16'hEC10, 16'h0000, 1'b1); tick();
    drive(16'h1234, 16'h0000, 1'b1); tick();
    drive(16'hE7C8, 16'h0000, 1'b1);
    expect_out("mwrite", 1'b1, 16'h0008, 1'b1, 15'h1234, 15'd3);
    tick();
    probe_d("mwrite_d", 16'h0007, 15'h1234, 15'd4);
    drive(16'hEC00, 16'h0000, 1'b0);
    expect_out("mwrite_a", 1'b1, 16'h1234, 1'b0, 15'h1234, 15'd4);
    tick();

    // Memory read: A=0x0010, D=M
    drive(16'h0010, 16'h0000, 1'b1); tick();
    drive(16'hFC10, 16'hBEEF, 1'b1);
    expect_out("mread", 1'b1, 16'hBEEF, 1'b0, 15'h0010, 15'd5);
    tick();
    probe_d("mread_d", 16'hBEEF, 15'h0010, 15'd6);

    // enable=0 for three cycles with M=D+1 applied
    for (int i = 0; i < 3; i++) begin
      drive(16'hE7C8, 16'h0000, 1'b0);
      expect_out("hold", 1'b1, 16'hBEF0, 1'b0, 15'h0010, 15'd6);
      tick();
    end
    probe_d("hold_d", 16'hBEEF, 15'h0010, 15'd6);

    // A=M;JMP: jump uses old A, A then takes inM
    drive(16'hFC27, 16'h0042, 1'b1);
    expect_out("amjmp_pre", 1'b1, 16'h0042, 1'b0, 15'h0010, 15'd6);
    tick();
    drive(16'hEC00, 16'h0000, 1'b0);
    expect_out("amjmp_post", 1'b1, 16'h0042, 1'b0, 15'h0042, 15'h0010);
    tick();

    // PC wrap from 0x7FFF
    drive(16'h7FFF, 16'h0000, 1'b1); tick();
    drive(16'hEA87, 16'h0000, 1'b1);
    expect_out("jmp_7fff", 1'b1, 16'h0000, 1'b0, 15'h7FFF, 15'h0011);
    tick();
    probe_d("pc_max", 16'hBEEF, 15'h7FFF, 15'h7FFF);
    drive(16'h0000, 16'h0000, 1'b1); tick();
    probe_d("pc_wrap", 16'hBEEF, 15'h0000, 15'h0000);

    // Reset mid-run between edges
    drive(16'h0123, 16'h0000, 1'b1); tick();
    drive(16'hE7C8, 16'h0000, 1'b1);
    expect_out("mid_wm", 1'b1, 16'hBEF0, 1'b1, 15'h0123, 15'd1);
    reset_n = 1'b0;
    expect_out("mid_rst", 1'b1, 16'h0001, 1'b0, 15'h0000, 15'h0000);
    tick();
    drive(16'hEC00, 16'h0000, 1'b1);
    expect_out("mid_rst_a", 1'b1, 16'h0000, 1'b0, 15'h0000, 15'h0000);
    tick();
    reset_n = 1'b1;

    // Resume at pc=0
    drive(16'h0003, 16'h0000, 1'b1); tick();
    drive(16'hEC00, 16'h0000, 1'b0);
    expect_out("resume", 1'b1, 16'h0003, 1'b0, 15'h0003, 15'd1);
    tick();

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
